// File: rtl/wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter
//
// Purpose:
//   Shares one unified Wishbone memory port between a core's instruction
//   fetch port (I) and data port (D). The arbiter grants one port per
//   transfer. Ties go to the port that was not granted last. A granted
//   transfer that gets no memory response within TIMEOUT_CYCLES cycles is
//   completed locally, so the core never stalls forever:
//     - D gets a bus error.
//     - I gets an all-zero instruction word, which is illegal and makes the
//       core trap.
//
// Parameters:
//   TIMEOUT_CYCLES  Number of cycles a granted transfer may wait for a
//                   response. 0 disables the timeout.
//
// Ports:
//   clk, rst_n                 Rising-edge clock; asynchronous active-low reset.
//   iwb_adr_i/cyc_i/stb_i      Fetch request from the core.
//   iwb_dat_o/ack_o            Fetch response to the core.
//   dwb_adr_i/dat_i/we_i/sel_i/cyc_i/stb_i
//                              Data request from the core.
//   dwb_dat_o/ack_o/err_o      Data response to the core.
//   m_adr_o/dat_o/we_o/sel_o/cyc_o/stb_o
//                              Request to unified memory.
//   m_dat_i/ack_i/err_i        Response from unified memory.
//   grant_o                    Current FSM state: 01 = I, 10 = D, 00 = idle.
//                              The state encoding is chosen to match this, so
//                              grant_o doubles as the state debug view.
//   timeout_o                  One-cycle pulse in the cycle a timeout
//                              completes a transfer.
//
// Handshake:
//   Every port uses classic Wishbone semantics.
//   - A master requests a transfer by holding cyc&stb. Both stay high until
//     the transfer ends.
//   - A response cycle (ack or err) completes the transfer. The request
//     fields are sampled during that cycle.
//   - Dropping cyc before a response aborts the transfer. After an abort,
//     no response is delivered.
//   - Responses are single-cycle pulses. After each response the arbiter
//     spends one cycle in IDLE, so a held request can never be answered
//     twice by the same ack.
// ---------------------------------------------------------------------------
module wb_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch port
  input  logic [31:0] iwb_adr_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  output logic [31:0] iwb_dat_o,
  output logic        iwb_ack_o,
  // data port
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_we_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  // unified memory port
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  // status
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  // The counter is at least 8 bits wide, and wider when the limit needs more bits.
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t        state;
  logic          last_gnt_d;  // 0 = I was granted last, 1 = D was granted last
  logic [CW-1:0] wait_cnt;    // cycles already spent in the current grant

  logic i_req;
  logic d_req;
  logic i_live;
  logic d_live;
  logic live;
  logic mem_resp;
  logic to_hit;

  assign i_req = iwb_cyc_i & iwb_stb_i;
  assign d_req = dwb_cyc_i & dwb_stb_i;

  // A grant is "live" only while its master keeps cyc high.
  // Once cyc drops, the transfer is aborted. From that cycle on, the bus is
  // released and responses are no longer routed back.
  assign i_live   = (state == GNT_I) & iwb_cyc_i;
  assign d_live   = (state == GNT_D) & dwb_cyc_i;
  assign live     = i_live | d_live;
  assign mem_resp = m_ack_i | m_err_i;

  // A real response arriving in the timeout cycle wins over the timeout.
  assign to_hit = TO_EN && live && (wait_cnt == TO_LIMIT) && !mem_resp;

  assign grant_o   = state;
  assign timeout_o = to_hit;

  // Outputs are decoded from the registered state. The granted port's
  // request fields and the memory response pass straight through.
  always_comb begin
    m_adr_o   = '0;
    m_dat_o   = '0;
    m_we_o    = 1'b0;
    m_sel_o   = 4'h0;
    m_cyc_o   = 1'b0;
    m_stb_o   = 1'b0;
    iwb_dat_o = '0;
    iwb_ack_o = 1'b0;
    dwb_dat_o = '0;
    dwb_ack_o = 1'b0;
    dwb_err_o = 1'b0;

    if (i_live) begin
      // Fetches are always full-word reads.
      m_adr_o   = iwb_adr_i;
      m_sel_o   = 4'hF;
      m_cyc_o   = ~to_hit;
      m_stb_o   = iwb_stb_i & ~to_hit;
      // I has no error input. An error or a timeout is delivered as an
      // all-zero instruction word.
      iwb_ack_o = mem_resp | to_hit;
      iwb_dat_o = (m_err_i | to_hit) ? 32'h0 : m_dat_i;
    end

    if (d_live) begin
      m_adr_o   = dwb_adr_i;
      m_dat_o   = dwb_dat_i;
      m_we_o    = dwb_we_i;
      m_sel_o   = dwb_sel_i;
      m_cyc_o   = ~to_hit;
      m_stb_o   = dwb_stb_i & ~to_hit;
      dwb_dat_o = m_dat_i;
      dwb_ack_o = m_ack_i & ~m_err_i;
      dwb_err_o = m_err_i | to_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_gnt_d <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (i_req && d_req) begin
            // Tie: grant whichever port did not win last time.
            if (last_gnt_d) begin
              state      <= GNT_I;
              last_gnt_d <= 1'b0;
            end else begin
              state      <= GNT_D;
              last_gnt_d <= 1'b1;
            end
          end else if (i_req) begin
            state      <= GNT_I;
            last_gnt_d <= 1'b0;
          end else if (d_req) begin
            state      <= GNT_D;
            last_gnt_d <= 1'b1;
          end
        end
        GNT_I, GNT_D: begin
          // Leave the grant on an abort, a response, or a timeout.
          // Otherwise count another waiting cycle.
          if (!live || mem_resp || to_hit) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;

  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] iwb_adr_i;
  logic        iwb_cyc_i;
  logic        iwb_stb_i;
  logic [31:0] iwb_dat_o;
  logic        iwb_ack_o;
  logic [31:0] dwb_adr_i;
  logic [31:0] dwb_dat_i;
  logic        dwb_we_i;
  logic [3:0]  dwb_sel_i;
  logic        dwb_cyc_i;
  logic        dwb_stb_i;
  logic [31:0] dwb_dat_o;
  logic        dwb_ack_o;
  logic        dwb_err_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic        m_we_o;
  logic [3:0]  m_sel_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;
  logic        m_err_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  wb_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
    .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
    .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i),
    .dwb_sel_i(dwb_sel_i), .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
    .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 = nobody, 1 = I, 2 = D.
  // waited: number of full cycles the owner has already waited.
  logic [1:0] mdl_owner = 2'd0;
  logic [1:0] mdl_last  = 2'd1;
  int         mdl_waited = 0;
  logic       mdl_ir;
  logic       mdl_dr;
  logic       mdl_live;

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      mdl_owner  = 2'd0;
      mdl_last   = 2'd1;
      mdl_waited = 0;
    end else if (mdl_owner == 2'd0) begin
      mdl_waited = 0;
      mdl_ir = iwb_cyc_i & iwb_stb_i;
      mdl_dr = dwb_cyc_i & dwb_stb_i;
      if (mdl_ir && mdl_dr) mdl_owner = (mdl_last == 2'd1) ? 2'd2 : 2'd1;
      else if (mdl_ir)      mdl_owner = 2'd1;
      else if (mdl_dr)      mdl_owner = 2'd2;
      if (mdl_owner != 2'd0) mdl_last = mdl_owner;
    end else begin
      mdl_live = (mdl_owner == 2'd1) ? iwb_cyc_i : dwb_cyc_i;
      if (!mdl_live || m_ack_i || m_err_i || (TO != 0 && mdl_waited == TO))
        mdl_owner = 2'd0;
      else
        mdl_waited++;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  logic srv_i;
  logic srv_d;
  logic e_resp;
  logic e_to;

  always @(negedge clk) begin : cmp
    srv_i  = (mdl_owner == 2'd1) && iwb_cyc_i;
    srv_d  = (mdl_owner == 2'd2) && dwb_cyc_i;
    e_resp = m_ack_i | m_err_i;
    e_to   = (TO != 0) && (srv_i || srv_d) && (mdl_waited == TO) && !e_resp;
    chk("cyc_grant",   32'(grant_o),   32'(mdl_owner));
    chk("cyc_m_adr",   m_adr_o,        srv_i ? iwb_adr_i : (srv_d ? dwb_adr_i : 32'h0));
    chk("cyc_m_dat",   m_dat_o,        srv_d ? dwb_dat_i : 32'h0);
    chk("cyc_m_we",    32'(m_we_o),    32'(srv_d & dwb_we_i));
    chk("cyc_m_sel",   32'(m_sel_o),   32'(srv_i ? 4'hF : (srv_d ? dwb_sel_i : 4'h0)));
    chk("cyc_m_cyc",   32'(m_cyc_o),   32'((srv_i | srv_d) & ~e_to));
    chk("cyc_m_stb",   32'(m_stb_o),   32'(((srv_i & iwb_stb_i) | (srv_d & dwb_stb_i)) & ~e_to));
    chk("cyc_iwb_ack", 32'(iwb_ack_o), 32'(srv_i & (e_resp | e_to)));
    chk("cyc_iwb_dat", iwb_dat_o,      (srv_i && !m_err_i && !e_to) ? m_dat_i : 32'h0);
    chk("cyc_dwb_ack", 32'(dwb_ack_o), 32'(srv_d & m_ack_i & ~m_err_i));
    chk("cyc_dwb_err", 32'(dwb_err_o), 32'(srv_d & (m_err_i | e_to)));
    chk("cyc_dwb_dat", dwb_dat_o,      srv_d ? m_dat_i : 32'h0);
    chk("cyc_timeout", 32'(timeout_o), 32'(e_to));
    chk("cyc_excl",    32'(iwb_ack_o & (dwb_ack_o | dwb_err_o)), 32'h0);
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    iwb_adr_i = '0; iwb_cyc_i = 0; iwb_stb_i = 0;
    dwb_adr_i = '0; dwb_dat_i = '0; dwb_we_i = 0; dwb_sel_i = '0;
    dwb_cyc_i = 0; dwb_stb_i = 0;
    m_dat_i = '0; m_ack_i = 0; m_err_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_on();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rst_cycle();
    rst_on();
    rst_n = 1;
  endtask

  task automatic d_request(input logic [31:0] adr, input logic [31:0] dat, input logic we);
    dwb_adr_i = adr; dwb_dat_i = dat; dwb_we_i = we; dwb_sel_i = 4'hF;
    dwb_cyc_i = 1; dwb_stb_i = 1;
  endtask

  // ---------------- directed tests with literal expectations ----------------
  logic [1:0] alt_tbl [8];
  logic [1:0] q_head;
  int         pulses;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    idle_inputs();

    // Reset state while both masters are already requesting.
    rst_on();
    iwb_cyc_i = 1; iwb_stb_i = 1; dwb_cyc_i = 1; dwb_stb_i = 1; m_ack_i = 1;
    @(posedge clk); #1;
    chk("rst_grant",   32'(grant_o),   32'h0);
    chk("rst_m_cyc",   32'(m_cyc_o),   32'h0);
    chk("rst_iwb_ack", 32'(iwb_ack_o), 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);

    // Single fetch with a 1-cycle memory latency.
    rst_cycle();
    iwb_adr_i = 32'h100; iwb_cyc_i = 1; iwb_stb_i = 1;
    #1 chk("f_c0_grant", 32'(grant_o), 32'h0);
    step();
    chk("f_c1_stb",   32'(m_stb_o), 32'h1);
    chk("f_c1_grant", 32'(grant_o), 32'h1);
    chk("f_c1_adr",   m_adr_o,      32'h100);
    chk("f_c1_sel",   32'(m_sel_o), 32'hF);
    chk("f_c1_ack",   32'(iwb_ack_o), 32'h0);
    step();
    m_ack_i = 1; m_dat_i = 32'h13;
    #1;
    chk("f_c2_ack", 32'(iwb_ack_o), 32'h1);
    chk("f_c2_dat", iwb_dat_o,      32'h13);
    chk("f_c2_dack", 32'(dwb_ack_o), 32'h0);
    step();
    m_ack_i = 0; iwb_cyc_i = 0; iwb_stb_i = 0;
    #1 chk("f_c3_grant", 32'(grant_o), 32'h0);

    // Both requests held from reset release: D, I, D, I with IDLE gaps.
    alt_tbl = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1};
    exp_q = {2'd2, 2'd1, 2'd2, 2'd1};
    rst_on();
    iwb_cyc_i = 1; iwb_stb_i = 1; dwb_cyc_i = 1; dwb_stb_i = 1; m_ack_i = 1;
    rst_n = 1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("alt_grant", 32'(grant_o), 32'(alt_tbl[i]));
      if (grant_o != 2'd0) begin
        if (exp_q.size() == 0) begin
          chk("alt_q_underflow", 32'(grant_o), 32'h0);
        end else begin
          q_head = exp_q.pop_front();
          chk("alt_q_order", 32'(grant_o), 32'(q_head));
        end
      end
      step();
    end
    chk("alt_q_left", 32'(exp_q.size()), 32'h0);

    // D store: request fields forwarded until ack; exactly one ack pulse.
    rst_cycle();
    d_request(32'h1000, 32'h1, 1'b1);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("st_adr", m_adr_o,       32'h1000);
      chk("st_dat", m_dat_o,       32'h1);
      chk("st_we",  32'(m_we_o),   32'h1);
      chk("st_sel", 32'(m_sel_o),  32'hF);
      if (dwb_ack_o) pulses++;
    end
    step();
    m_ack_i = 1;
    #1;
    chk("st_ack_adr", m_adr_o, 32'h1000);
    if (dwb_ack_o) pulses++;
    step();
    m_ack_i = 0; dwb_cyc_i = 0; dwb_stb_i = 0;
    for (int c = 0; c < 3; c++) begin
      #1 if (dwb_ack_o) pulses++;
      step();
    end
    chk("st_pulses", 32'(pulses), 32'h1);

    // D timeout with silent memory: error in the 5th granted cycle.
    rst_cycle();
    d_request(32'h2000, 32'h0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      if (c < 4) begin
        chk("dto_wait_to",  32'(timeout_o), 32'h0);
        chk("dto_wait_err", 32'(dwb_err_o), 32'h0);
      end
    end
    chk("dto_err",   32'(dwb_err_o), 32'h1);
    chk("dto_to",    32'(timeout_o), 32'h1);
    chk("dto_mcyc",  32'(m_cyc_o),   32'h0);
    chk("dto_ack",   32'(dwb_ack_o), 32'h0);
    step();
    chk("dto_idle", 32'(grant_o), 32'h0);
    dwb_cyc_i = 0; dwb_stb_i = 0;

    // I timeout: all-zero instruction even with junk on the data bus.
    rst_cycle();
    iwb_adr_i = 32'h300; iwb_cyc_i = 1; iwb_stb_i = 1; m_dat_i = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) step();
    chk("ito_ack", 32'(iwb_ack_o), 32'h1);
    chk("ito_dat", iwb_dat_o,      32'h0);
    chk("ito_to",  32'(timeout_o), 32'h1);
    step();
    chk("ito_idle", 32'(grant_o), 32'h0);
    iwb_cyc_i = 0; iwb_stb_i = 0;

    // A real ack in the timeout cycle takes precedence.
    rst_cycle();
    d_request(32'h2004, 32'h0, 1'b0);
    for (int c = 0; c < 5; c++) step();
    m_ack_i = 1; m_dat_i = 32'h55;
    #1;
    chk("late_ack",  32'(dwb_ack_o), 32'h1);
    chk("late_to",   32'(timeout_o), 32'h0);
    chk("late_err",  32'(dwb_err_o), 32'h0);
    chk("late_dat",  dwb_dat_o,      32'h55);
    step();
    m_ack_i = 0; dwb_cyc_i = 0; dwb_stb_i = 0;

    // ack and err together on a D read: the error wins.
    rst_cycle();
    d_request(32'h2008, 32'h0, 1'b0);
    step();
    m_ack_i = 1; m_err_i = 1;
    #1;
    chk("ae_err", 32'(dwb_err_o), 32'h1);
    chk("ae_ack", 32'(dwb_ack_o), 32'h0);
    step();
    m_ack_i = 0; m_err_i = 0; dwb_cyc_i = 0; dwb_stb_i = 0;

    // Abort: I drops cyc mid-grant; a later ack is ignored.
    rst_cycle();
    iwb_adr_i = 32'h400; iwb_cyc_i = 1; iwb_stb_i = 1;
    step();
    step();
    iwb_cyc_i = 0; iwb_stb_i = 0;
    #1;
    chk("ab_mcyc", 32'(m_cyc_o), 32'h0);
    chk("ab_mstb", 32'(m_stb_o), 32'h0);
    step();
    m_ack_i = 1;
    #1;
    chk("ab_grant", 32'(grant_o),   32'h0);
    chk("ab_ack",   32'(iwb_ack_o), 32'h0);
    step();
    m_ack_i = 0;

    // Reset pulse mid-transfer; a late ack afterwards has no effect.
    rst_cycle();
    d_request(32'h3000, 32'h0, 1'b0);
    m_dat_i = 32'hA5A5A5A5;
    step();
    step();
    #1 rst_n = 0;
    #1;
    chk("mr_grant", 32'(grant_o),   32'h0);
    chk("mr_mcyc",  32'(m_cyc_o),   32'h0);
    chk("mr_madr",  m_adr_o,        32'h0);
    chk("mr_ddat",  dwb_dat_o,      32'h0);
    dwb_cyc_i = 0; dwb_stb_i = 0; m_ack_i = 1;
    @(posedge clk); #1;
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mr_late_ack", 32'(dwb_ack_o), 32'h0);
    end
    m_ack_i = 0;

    // Randomized traffic against the model. Every third block of 100 cycles
    // keeps memory silent so that timeouts occur.
    rst_cycle();
    for (int n = 0; n < 3000; n++) begin
      step();
      iwb_cyc_i = ($urandom_range(0, 9) < 8);
      iwb_stb_i = iwb_cyc_i && ($urandom_range(0, 3) != 0);
      iwb_adr_i = $urandom;
      dwb_cyc_i = ($urandom_range(0, 9) < 8);
      dwb_stb_i = dwb_cyc_i && ($urandom_range(0, 3) != 0);
      dwb_adr_i = $urandom;
      dwb_dat_i = $urandom;
      dwb_we_i  = 1'($urandom_range(0, 1));
      dwb_sel_i = 4'($urandom_range(0, 15));
      m_dat_i   = $urandom;
      if (((n / 100) % 3) == 2) begin
        m_ack_i = 0;
        m_err_i = 0;
      end else begin
        m_ack_i = ($urandom_range(0, 9) < 3);
        m_err_i = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 0;
        #1 rst_n = 1;
      end
    end

    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
